// File: rtl/pipe_in_check_pkg.sv
// Shared definitions for the pipe-in data checker and its pattern generator.
//   SEED_LFSR / SEED_COUNT : reseed values for the two pattern modes
//   LFSR_TAP_*             : feedback taps of x^32 + x^22 + x^2 + 1
//   state_e                : checker control state encoding
//   next_half()            : advance one 32-bit half of the pattern
package pipe_in_check_pkg;

  localparam logic [63:0] SEED_LFSR  = 64'h0D0C_0B0A_0403_0201;
  localparam logic [63:0] SEED_COUNT = 64'h0000_0001_0000_0001;

  localparam int LFSR_TAP_MSB = 31;
  localparam int LFSR_TAP_A   = 21;
  localparam int LFSR_TAP_B   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] next_half(input logic lfsr_mode, input logic [31:0] t);
    if (lfsr_mode) begin
      return {t[30:0], t[LFSR_TAP_MSB] ^ t[LFSR_TAP_A] ^ t[LFSR_TAP_B]};
    end
    return t + 32'd1;
  endfunction

  function automatic logic [63:0] seed_for(input logic lfsr_mode);
    return lfsr_mode ? SEED_LFSR : SEED_COUNT;
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// 64-bit test-pattern register, usable by both the receive checker and a
// transmit-side generator.
//   clk, reset_n : clock, asynchronous active-low reset (pattern -> SEED_COUNT)
//   load         : reseed from seed_for(mode); has priority over advance
//   advance      : step both 32-bit halves independently in the given mode
//   mode         : 0 = counting halves, 1 = LFSR halves
//   pattern      : current pattern value
module pipe_pattern_gen
  import pipe_in_check_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  logic        mode,
  output logic [63:0] pattern
);

  logic [63:0] pattern_d;
  logic [63:0] pattern_q;

  always_comb begin
    pattern_d = pattern_q;
    if (load) begin
      pattern_d = seed_for(mode);
    end else if (advance) begin
      pattern_d = {next_half(mode, pattern_q[63:32]), next_half(mode, pattern_q[31:0])};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= SEED_COUNT;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;

endmodule

// File: rtl/pipe_in_check.sv
// Receive-side pipe data checker: pulls words from a FIFO under a rotating
// throttle mask and compares them against a locally generated pattern.
//   clk, reset_n      : clock, asynchronous active-low reset
//   pipe_in_start     : reseed, clear counters, enter RUN (mode sampled here)
//   pipe_in_read      : registered FIFO read strobe
//   pipe_in_valid     : FIFO data valid, one cycle after an accepted read
//   pipe_in_data      : FIFO read data
//   pipe_in_rd_count  : FIFO fill level in words
//   throttle_set/_val : load the throttle rotation mask
//   mode              : 0 = count pattern, 1 = LFSR pattern
//   word_count        : words compared since start
//   error_count       : mismatching words, saturating
//   error_flag        : sticky, set on first mismatch
//   first_err_index   : word_count of the first mismatching word
module pipe_in_check
  import pipe_in_check_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_in_start,
  output logic        pipe_in_read,
  input  logic        pipe_in_valid,
  input  logic [63:0] pipe_in_data,
  input  logic [8:0]  pipe_in_rd_count,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic        mode,
  output logic [31:0] word_count,
  output logic [31:0] error_count,
  output logic        error_flag,
  output logic [31:0] first_err_index
);

  state_e      state_d, state_q;
  logic        mode_d, mode_q;
  logic [31:0] throttle_d, throttle_q;
  logic        read_d, read_q;
  logic [31:0] word_count_d, word_count_q;
  logic [31:0] error_count_d, error_count_q;
  logic        error_flag_d, error_flag_q;
  logic [31:0] first_err_index_d, first_err_index_q;

  logic        compare;
  logic        mismatch;
  logic        space_ok;
  logic        gen_mode;
  logic [63:0] expected;

  // On the start cycle the generator must seed from the incoming mode, not
  // the previously latched one.
  assign gen_mode = pipe_in_start ? mode : mode_q;

  pipe_pattern_gen u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pipe_in_start),
    .advance (compare),
    .mode    (gen_mode),
    .pattern (expected)
  );

  always_comb begin
    // Start wins over a coincident valid word: it is dropped uncompared.
    compare  = (state_q == ST_RUN) && pipe_in_valid && !pipe_in_start;
    mismatch = compare && (pipe_in_data != expected);

    state_d    = pipe_in_start ? ST_RUN : state_q;
    mode_d     = pipe_in_start ? mode : mode_q;
    throttle_d = throttle_set ? throttle_val : {throttle_q[0], throttle_q[31:1]};

    // A read issued last cycle has not yet lowered rd_count, so a single
    // remaining word may only be requested if no read is already in flight.
    space_ok = (pipe_in_rd_count >= 9'd2) || ((pipe_in_rd_count == 9'd1) && !read_q);
    read_d   = (state_q == ST_RUN) && throttle_q[0] && space_ok;

    word_count_d      = word_count_q;
    error_count_d     = error_count_q;
    error_flag_d      = error_flag_q;
    first_err_index_d = first_err_index_q;
    if (pipe_in_start) begin
      word_count_d      = '0;
      error_count_d     = '0;
      error_flag_d      = 1'b0;
      first_err_index_d = '0;
    end else if (compare) begin
      word_count_d = word_count_q + 32'd1;
      if (mismatch) begin
        if (error_count_q != 32'hFFFF_FFFF) begin
          error_count_d = error_count_q + 32'd1;
        end
        if (!error_flag_q) begin
          error_flag_d      = 1'b1;
          first_err_index_d = word_count_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      mode_q            <= 1'b0;
      throttle_q        <= 32'hFFFF_FFFF;
      read_q            <= 1'b0;
      word_count_q      <= '0;
      error_count_q     <= '0;
      error_flag_q      <= 1'b0;
      first_err_index_q <= '0;
    end else begin
      state_q           <= state_d;
      mode_q            <= mode_d;
      throttle_q        <= throttle_d;
      read_q            <= read_d;
      word_count_q      <= word_count_d;
      error_count_q     <= error_count_d;
      error_flag_q      <= error_flag_d;
      first_err_index_q <= first_err_index_d;
    end
  end

  assign pipe_in_read    = read_q;
  assign word_count      = word_count_q;
  assign error_count     = error_count_q;
  assign error_flag      = error_flag_q;
  assign first_err_index = first_err_index_q;

endmodule

// File: tb/tb_pipe_in_check.sv
// Directed bench for pipe_in_check.
module tb_pipe_in_check;

  logic        clk;
  logic        reset_n;
  logic        pipe_in_start;
  logic        pipe_in_read;
  logic        pipe_in_valid;
  logic [63:0] pipe_in_data;
  logic [8:0]  pipe_in_rd_count;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic        mode;
  logic [31:0] word_count;
  logic [31:0] error_count;
  logic        error_flag;
  logic [31:0] first_err_index;

  int checks;
  int failures;

  pipe_in_check dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pipe_in_start    (pipe_in_start),
    .pipe_in_read     (pipe_in_read),
    .pipe_in_valid    (pipe_in_valid),
    .pipe_in_data     (pipe_in_data),
    .pipe_in_rd_count (pipe_in_rd_count),
    .throttle_set     (throttle_set),
    .throttle_val     (throttle_val),
    .mode             (mode),
    .word_count       (word_count),
    .error_count      (error_count),
    .error_flag       (error_flag),
    .first_err_index  (first_err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic m);
    mode          = m;
    pipe_in_start = 1'b1;
    tick();
    pipe_in_start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] d);
    pipe_in_valid = 1'b1;
    pipe_in_data  = d;
    tick();
    pipe_in_valid = 1'b0;
    pipe_in_data  = '0;
  endtask

  task automatic set_throttle(input logic [31:0] v);
    throttle_set = 1'b1;
    throttle_val = v;
    tick();
    throttle_set = 1'b0;
  endtask

  // x^32 + x^22 + x^2 + 1 step of one half.
  function automatic logic [31:0] lfsr_step(input logic [31:0] t);
    return {t[30:0], t[31] ^ t[21] ^ t[1]};
  endfunction

  initial begin
    logic [63:0] w;
    int          pulses;
    int          consec;
    logic        prev;

    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    pipe_in_start    = 1'b0;
    pipe_in_valid    = 1'b0;
    pipe_in_data     = '0;
    pipe_in_rd_count = '0;
    throttle_set     = 1'b0;
    throttle_val     = '0;
    mode             = 1'b0;

    // Reset state, including garbage on valid while held in reset
    tick();
    pipe_in_valid = 1'b1;
    pipe_in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    pipe_in_rd_count = 9'd256;
    tick();
    chk("rst_read", pipe_in_read, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_ec", error_count, 0);
    chk("rst_flag", error_flag, 0);
    chk("rst_idx", first_err_index, 0);
    reset_n = 1'b1;

    // IDLE ignores valid and never reads
    tick();
    tick();
    chk("idle_wc", word_count, 0);
    chk("idle_ec", error_count, 0);
    chk("idle_read", pipe_in_read, 0);
    pipe_in_valid    = 1'b0;
    pipe_in_rd_count = '0;

    // Count mode: 1..10 in both halves
    start_run(1'b0);
    for (int i = 1; i <= 10; i++) begin
      w = {32'(i), 32'(i)};
      feed(w);
      if (i == 3) chk("cnt_wc3", word_count, 3);
    end
    chk("cnt_wc", word_count, 10);
    chk("cnt_ec", error_count, 0);
    chk("cnt_flag", error_flag, 0);

    // LFSR mode: 8 words, 5th word bit 0 flipped
    start_run(1'b1);
    chk("lfsr_clr_wc", word_count, 0);
    w = 64'h0D0C_0B0A_0403_0201;
    for (int i = 0; i < 8; i++) begin
      feed((i == 4) ? (w ^ 64'h1) : w);
      if (i == 4) begin
        chk("lfsr_ec5", error_count, 1);
        chk("lfsr_flag5", error_flag, 1);
        chk("lfsr_idx5", first_err_index, 4);
      end
      w = {lfsr_step(w[63:32]), lfsr_step(w[31:0])};
    end
    chk("lfsr_wc", word_count, 8);
    chk("lfsr_ec", error_count, 1);
    chk("lfsr_idx", first_err_index, 4);

    // Start coincident with valid: word dropped, then seed word matches
    pipe_in_valid = 1'b1;
    pipe_in_data  = 64'h1234_5678_9ABC_DEF0;
    start_run(1'b0);
    pipe_in_valid = 1'b0;
    chk("stv_wc", word_count, 0);
    feed(64'h0000_0001_0000_0001);
    chk("stv_wc1", word_count, 1);
    chk("stv_ec", error_count, 0);

    // Throttle 0x00000001 with full FIFO: one read per 32 cycles
    set_throttle(32'h0000_0001);
    pipe_in_rd_count = 9'd256;
    pulses = 0;
    for (int i = 0; i < 320; i++) begin
      tick();
      if (pipe_in_read) pulses++;
    end
    chk("thr_pulses", 64'(pulses), 10);

    // rd_count held at 1: never two reads back-to-back
    set_throttle(32'hFFFF_FFFF);
    pipe_in_rd_count = 9'd1;
    tick();
    pulses = 0;
    consec = 0;
    prev   = pipe_in_read;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pipe_in_read) pulses++;
      if (pipe_in_read && prev) consec++;
      prev = pipe_in_read;
    end
    chk("rd1_consec", 64'(consec), 0);
    chk("rd1_pulses", 64'(pulses), 10);
    pipe_in_rd_count = '0;

    // Saturation: preload error_count at 0xFFFFFFFE, then 3 bad words
    start_run(1'b0);
    force dut.error_count_d = 32'hFFFF_FFFE;
    tick();
    release dut.error_count_d;
    #1;
    chk("sat_pre", error_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      feed(64'h0);
      chk("sat_ec", error_count, 32'hFFFF_FFFF);
    end
    chk("sat_wc", word_count, 3);
    chk("sat_idx", first_err_index, 0);

    // Reset mid-RUN with reads active and counters non-zero
    start_run(1'b0);
    pipe_in_rd_count = 9'd256;
    feed(64'h0000_0001_0000_0001);
    feed(64'h0);
    tick();
    chk("mid_read_on", pipe_in_read, 1);
    chk("mid_ec_pre", error_count, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_read", pipe_in_read, 0);
    chk("mid_wc", word_count, 0);
    chk("mid_ec", error_count, 0);
    chk("mid_flag", error_flag, 0);
    chk("mid_idx", first_err_index, 0);
    tick();
    reset_n          = 1'b1;
    pipe_in_rd_count = '0;
    tick();
    chk("mid_idle_read", pipe_in_read, 0);
    start_run(1'b0);
    feed(64'h0000_0001_0000_0001);
    feed(64'h0000_0002_0000_0002);
    chk("re_wc", word_count, 2);
    chk("re_ec", error_count, 0);
    chk("re_flag", error_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
